// File: rtl/mips_reg_file.sv
// rtl/mips_reg_file.sv - 32x32 MIPS register file with MOVZ/MOVN conditional writes and debug read.
// Optional same-cycle write-to-read bypass enabled by defining REG_FILE_BYPASS_EN.
module mips_reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] Rs_addr,
  input  logic [ADDR_W-1:0] Rt_addr,
  output logic [DATA_W-1:0] Data_out_A,
  output logic [DATA_W-1:0] Data_out_B,
  input  logic              Wr_en,
  input  logic [1:0]        Wr_cond,
  input  logic [DATA_W-1:0] Cond_val,
  input  logic [ADDR_W-1:0] Wr_addr,
  input  logic [DATA_W-1:0] Wr_data,
  input  logic [ADDR_W-1:0] Dbg_addr,
  output logic [DATA_W-1:0] Dbg_data,
  output logic              Wr_done
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic              cond_pass;
  logic              commit;

  always_comb begin
    cond_pass = 1'b0;
    case (Wr_cond)
      2'b00:   cond_pass = 1'b1;
      2'b01:   cond_pass = (Cond_val == '0);
      2'b10:   cond_pass = (Cond_val != '0);
      default: cond_pass = 1'b0;
    endcase
  end

  assign commit = Wr_en && (Wr_addr != '0) && cond_pass;

  // Entry 0 is never written, so it holds its reset value of zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      Wr_done <= 1'b0;
    end else begin
      if (commit) regs[Wr_addr] <= Wr_data;
      Wr_done <= commit;
    end
  end

  always_comb begin
    Data_out_A = '0;
    Data_out_B = '0;
    Dbg_data   = '0;
    if (!rst) begin
      if (Rs_addr  != '0) Data_out_A = regs[Rs_addr];
      if (Rt_addr  != '0) Data_out_B = regs[Rt_addr];
      if (Dbg_addr != '0) Dbg_data   = regs[Dbg_addr];
`ifdef REG_FILE_BYPASS_EN
      // commit already excludes index 0 and failed conditions.
      if (commit && Rs_addr  == Wr_addr) Data_out_A = Wr_data;
      if (commit && Rt_addr  == Wr_addr) Data_out_B = Wr_data;
      if (commit && Dbg_addr == Wr_addr) Dbg_data   = Wr_data;
`endif
    end
  end

endmodule
